aes_inv_cipher: RTL

- Iterative AES-128 inverse cipher (FIPS-197 §5.3): ciphertext + cipher key in, plaintext out.
- Decrypt-side counterpart of the pipelined `cipher` block; same 128-bit, MSB-first data convention.
- One inverse round per clock.
- Round keys are expanded forward into a local schedule store, then consumed in reverse order.

---
 rtl/aes_inv_cipher.sv | 271 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/aes_inv_cipher.sv
// aes_inv_cipher: iterative AES-128 inverse cipher, one inverse round per clock.
//   clk       : system clock, rising edge
//   rst_n     : asynchronous active-low reset (aborts any job in flight)
//   valid_in  : request; {in, key} are taken on an edge where valid_in && ready
//   ready     : idle and able to accept a request
//   in        : ciphertext, byte 0 = in[0:7], column-major state order
//   key       : cipher key, same byte order
//   out       : plaintext, held until the next completion
//   valid_out : one-cycle pulse marking a new out
// Flow: the key is expanded forward (one round key per clock) into a local
// schedule, then the inverse rounds consume it from rk[10] down to rk[0].
// Job latency is 20 clocks from accept to valid_out.
// Optional macro AES_INV_KEY_CACHE_EN: remembers the last expanded key; a
// request with the same key skips expansion and completes in 10 clocks.
module aes_inv_cipher #(
  parameter int Nk = 4,
  parameter int Nr = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         valid_in,
  output logic         ready,
  input  logic [0:127] in,
  input  logic [0:127] key,
  output logic [0:127] out,
  output logic         valid_out
);
  if ((Nk != 4) || (Nr != 10)) begin : g_bad_params
    $error("aes_inv_cipher supports only Nk=4 and Nr=10");
  end

  // Forward S-box, needed by SubWord in the key schedule.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

  localparam logic [2047:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d};

  function automatic logic [7:0] sub_byte(input logic [7:0] b);
    return SBOX[2047 - 8 * int'(b) -: 8];
  endfunction

  function automatic logic [7:0] inv_sub_byte(input logic [7:0] b);
    return INV_SBOX[2047 - 8 * int'(b) -: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // One column of InvMixColumns; the 0e/0b/0d/09 multiples share one
  // x2/x4/x8 xtime chain per byte.
  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0] a, x2, x4, x8;
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    for (int i = 0; i < 4; i++) begin
      a  = col[31 - 8 * i -: 8];
      x2 = xtime(a);
      x4 = xtime(x2);
      x8 = xtime(x4);
      m9[i] = x8 ^ a;
      mb[i] = x8 ^ x2 ^ a;
      md[i] = x8 ^ x4 ^ a;
      me[i] = x8 ^ x4 ^ x2;
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3], m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3], mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

  // InvShiftRows followed by InvSubBytes: row r of column c comes from
  // column (c - r) mod 4.
  function automatic logic [127:0] inv_shift_sub(input logic [127:0] s);
    logic [127:0] r_out;
    int src;
    r_out = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        src = (c - r + 4) % 4;
        r_out[127 - 8 * (r + 4 * c) -: 8] = inv_sub_byte(s[127 - 8 * (r + 4 * src) -: 8]);
      end
    end
    return r_out;
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [127:0] key_step(input logic [127:0] prev, input logic [7:0] rc);
    logic [31:0] t, n0, n1, n2, n3;
    t  = {sub_byte(prev[23:16]), sub_byte(prev[15:8]), sub_byte(prev[7:0]),
          sub_byte(prev[31:24])} ^ {rc, 24'h0};
    n0 = prev[127:96] ^ t;
    n1 = prev[95:64] ^ n0;
    n2 = prev[63:32] ^ n1;
    n3 = prev[31:0] ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  typedef enum logic [1:0] {IDLE, KEYEXP, DEC} fsm_e;

  fsm_e         fsm_q, fsm_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [127:0] state_q, state_d;
  logic [127:0] rk_q [11];
  logic [127:0] rk_d [11];
  logic [127:0] out_q, out_d;
  logic         ready_q, ready_d;
  logic         valid_out_q, valid_out_d;

  logic [127:0] in_w, key_w, rk_prev, rk_cur, key_next, round_xor, mix_out;
  logic         accept, cache_hit;

  assign in_w   = in;
  assign key_w  = key;
  assign accept = valid_in && ready_q;

  // cnt_q selects the round key being written (KEYEXP) or consumed (DEC).
  always_comb begin
    rk_prev = '0;
    rk_cur  = '0;
    for (int i = 0; i < 11; i++) begin
      if (4'(i) == cnt_q)     rk_cur  = rk_q[i];
      if (4'(i + 1) == cnt_q) rk_prev = rk_q[i];
    end
  end

  assign key_next  = key_step(rk_prev, rcon(cnt_q));
  assign round_xor = inv_shift_sub(state_q) ^ rk_cur;

  for (genvar gi = 0; gi < 4; gi++) begin : g_imc
    assign mix_out[127 - 32 * gi -: 32] = inv_mix_col(round_xor[127 - 32 * gi -: 32]);
  end

`ifdef AES_INV_KEY_CACHE_EN
  logic [127:0] cached_key_q, cached_key_d;
  logic         cache_valid_q, cache_valid_d;

  // rk[] still holds the schedule of cached_key_q while cache_valid_q is set,
  // because only a miss rewrites the schedule.
  assign cache_hit = cache_valid_q && (key_w == cached_key_q);

  always_comb begin
    cached_key_d  = cached_key_q;
    cache_valid_d = cache_valid_q;
    if (accept && !cache_hit) begin
      cached_key_d  = key_w;
      cache_valid_d = 1'b0;
    end else if ((fsm_q == KEYEXP) && (cnt_q == 4'd10)) begin
      cache_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cached_key_q  <= '0;
      cache_valid_q <= 1'b0;
    end else begin
      cached_key_q  <= cached_key_d;
      cache_valid_q <= cache_valid_d;
    end
  end
`else
  assign cache_hit = 1'b0;
`endif

  always_comb begin
    fsm_d       = fsm_q;
    cnt_d       = cnt_q;
    state_d     = state_q;
    rk_d        = rk_q;
    out_d       = out_q;
    ready_d     = ready_q;
    valid_out_d = 1'b0;
    case (fsm_q)
      IDLE: begin
        if (accept) begin
          ready_d = 1'b0;
          if (cache_hit) begin
            state_d = in_w ^ rk_q[10];
            cnt_d   = 4'd9;
            fsm_d   = DEC;
          end else begin
            state_d  = in_w;
            rk_d[0]  = key_w;
            cnt_d    = 4'd1;
            fsm_d    = KEYEXP;
          end
        end
      end
      KEYEXP: begin
        for (int i = 1; i < 11; i++) begin
          if (4'(i) == cnt_q) rk_d[i] = key_next;
        end
        if (cnt_q == 4'd10) begin
          // Initial AddRoundKey uses rk[10] straight from the expansion logic.
          state_d = state_q ^ key_next;
          cnt_d   = 4'd9;
          fsm_d   = DEC;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      DEC: begin
        if (cnt_q == 4'd0) begin
          out_d       = round_xor;
          valid_out_d = 1'b1;
          ready_d     = 1'b1;
          fsm_d       = IDLE;
        end else begin
          state_d = mix_out;
          cnt_d   = cnt_q - 4'd1;
        end
      end
      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q       <= IDLE;
      cnt_q       <= '0;
      state_q     <= '0;
      for (int i = 0; i < 11; i++) rk_q[i] <= '0;
      out_q       <= '0;
      ready_q     <= 1'b1;
      valid_out_q <= 1'b0;
    end else begin
      fsm_q       <= fsm_d;
      cnt_q       <= cnt_d;
      state_q     <= state_d;
      rk_q        <= rk_d;
      out_q       <= out_d;
      ready_q     <= ready_d;
      valid_out_q <= valid_out_d;
    end
  end

  assign ready     = ready_q;
  assign valid_out = valid_out_q;
  assign out       = out_q;
endmodule
